pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Responder side of the hazard interface: consumes the hazard unit's stall request, the SRAM controller's ready signal and the EXE-stage branch decision.
- Drives the freeze, flush and bubble controls of the 5-stage pipeline registers.
- Sits at pipeline top level between the hazard unit, the memory controller and the PC / IF-ID / ID-EXE / EXE-MEM / MEM-WB registers.
- Keeps saturating performance counters and a stall watchdog.

Parameters:
- CNT_W, 32, width of each performance counter.
- WDOG_CYCLES, 1024, consecutive stalled cycles that trip the watchdog.
- WDOG_W, 11, watchdog counter width; must satisfy 2^WDOG_W > WDOG_CYCLES.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- hazard  in  1  RAW stall request from hazard unit
- mem_ready  in  1  low = memory access in progress, global freeze
- branch_taken  in  1  EXE-stage branch resolved taken
- clr_counters  in  1  synchronous clear of performance counters
- freeze_pc  out  1  hold PC
- freeze_if_id  out  1  hold IF/ID register
- freeze_back  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers
- flush_if_id  out  1  load NOP into IF/ID
- bubble_id_exe  out  1  load NOP into ID/EXE
- stall_cycles  out  CNT_W  cycles with freeze_pc=1
- flush_count  out  CNT_W  branch flushes issued
- bubble_count  out  CNT_W  hazard bubbles issued
- wdog_trip  out  1  sticky watchdog error

Behaviour:
- One clock domain; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset: state=RUN, br_pending=0, all counters=0, wdog_cnt=0, wdog_trip=0.
- Control outputs are combinational (Mealy) from state, br_pending and inputs, so they take effect in the same cycle. Counters and the FSM are registered.
- States:
  - RUN
  - MEM_STALL
- Priority in RUN:
  - mem_ready=0: freeze_pc=freeze_if_id=freeze_back=1, no flush, no bubble. If branch_taken=1, set br_pending. Next state MEM_STALL.
  - Else branch_taken=1: flush_if_id=1 and bubble_id_exe=1, no freeze. hazard is ignored because the stalled instruction is being squashed. flush_count+1.
  - Else hazard=1: freeze_pc=freeze_if_id=1, bubble_id_exe=1, freeze_back=0. bubble_count+1.
  - Else: all control outputs 0.
- MEM_STALL:
  - While mem_ready=0: full freeze as above. branch_taken=1 in any of these cycles sets br_pending.
  - mem_ready=1: go to RUN and evaluate the RUN rules in this same cycle, with effective branch = branch_taken OR br_pending. Clear br_pending.
  - A pending branch plus a still-asserted branch_taken yields exactly one flush (flush_count+1).
- stall_cycles increments every cycle freeze_pc=1 (memory or hazard).
- Counters saturate at all-ones and never wrap.
- clr_counters=1: all three counters become 0 next edge. Clear wins over a coincident increment.
- Watchdog:
  - wdog_cnt increments each cycle freeze_pc=1 and resets to 0 on any cycle freeze_pc=0.
  - When wdog_cnt reaches WDOG_CYCLES-1 while stalled, wdog_trip sets on that edge.
  - wdog_trip is sticky until rst and does not alter pipeline control.
- Reset mid-stall: outputs drop immediately (asynchronous) and any pending branch is lost. This is acceptable because the PC also resets.

Decomposition:
- Shared pipeline control package holds the state encoding (RUN=1'b0, MEM_STALL=1'b1) and the default widths CNT_W=32 and WDOG_CYCLES=1024.
- One sub-module, sat_counter (parameter W; inputs inc, clr; output cnt), instantiated three times.
- The watchdog counter stays inline.

Test Plan:
- hazard=1 for 2 cycles, mem_ready=1 -> freeze_pc=freeze_if_id=bubble_id_exe=1 both cycles, freeze_back=0; bubble_count=2, stall_cycles=2.
- branch_taken=1 and hazard=1 in the same cycle -> flush_if_id=bubble_id_exe=1, freeze_pc=0; flush_count=1, bubble_count=0.
- mem_ready=0 for 5 cycles, branch_taken pulses in cycle 2 -> full freeze 5 cycles, no flush. On release cycle: flush_if_id=1 once, flush_count=1, stall_cycles=5.
- Same as previous but branch_taken held high through release -> exactly one flush, flush_count=1.
- WDOG_CYCLES=8, mem_ready=0 for 10 cycles -> wdog_trip rises after edge 8 and stays 1 after mem_ready=1. Only rst clears it.
- Preload stall_cycles to all-ones via forced stall with CNT_W=4 (16 stalls) -> value holds 15. Then clr_counters with hazard=1 in the same cycle -> all counters 0.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline control definitions: FSM encoding, default widths and the
// RUN-state control decode used by the stall controller.
package pipeline_stall_controller_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        MEM_STALL = 1'b1
    } state_e;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_WDOG_CYCLES = 1024;
    localparam int DEF_WDOG_W      = 11;

    typedef struct packed {
        logic freeze_pc;
        logic freeze_if_id;
        logic freeze_back;
        logic flush_if_id;
        logic bubble_id_exe;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_FLUSH  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_BUBBLE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // A taken branch squashes the instruction the hazard unit wants to stall,
    // so branch beats hazard.
    function automatic ctrl_t run_ctrl(input logic branch, input logic hazard);
        if (branch) begin
            return CTRL_FLUSH;
        end else if (hazard) begin
            return CTRL_BUBBLE;
        end
        return CTRL_IDLE;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline freeze/flush/bubble controller: Mealy decode of hazard, memory
// ready and branch, with a pending-branch latch across memory stalls.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES,
    parameter int WDOG_W      = DEF_WDOG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             mem_ready,
    input  logic             branch_taken,
    input  logic             clr_counters,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             freeze_back,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] bubble_count,
    output logic             wdog_trip
);

    state_e              state;
    state_e              state_next;
    logic                br_pending;
    logic                br_pending_next;
    ctrl_t               ctrl;
    logic                inc_stall;
    logic                inc_flush;
    logic                inc_bubble;
    logic [WDOG_W-1:0]   wdog_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            br_pending <= 1'b0;
        end else begin
            state      <= state_next;
            br_pending <= br_pending_next;
        end
    end

    always_comb begin
        state_next      = state;
        br_pending_next = br_pending;
        ctrl            = CTRL_IDLE;
        case (state)
            RUN: begin
                if (!mem_ready) begin
                    ctrl            = CTRL_FREEZE;
                    state_next      = MEM_STALL;
                    br_pending_next = branch_taken;
                end else begin
                    ctrl = run_ctrl(branch_taken, hazard);
                end
            end
            MEM_STALL: begin
                if (!mem_ready) begin
                    ctrl = CTRL_FREEZE;
                    if (branch_taken) begin
                        br_pending_next = 1'b1;
                    end
                end else begin
                    // Release cycle: the remembered branch and a live one merge into one flush.
                    ctrl            = run_ctrl(branch_taken | br_pending, hazard);
                    state_next      = RUN;
                    br_pending_next = 1'b0;
                end
            end
            default: begin
                state_next      = RUN;
                br_pending_next = 1'b0;
            end
        endcase
        // Controls drop the moment reset asserts, independent of the inputs.
        if (rst) begin
            ctrl = CTRL_IDLE;
        end
    end

    assign freeze_pc     = ctrl.freeze_pc;
    assign freeze_if_id  = ctrl.freeze_if_id;
    assign freeze_back   = ctrl.freeze_back;
    assign flush_if_id   = ctrl.flush_if_id;
    assign bubble_id_exe = ctrl.bubble_id_exe;

    assign inc_stall  = ctrl.freeze_pc;
    assign inc_flush  = ctrl.flush_if_id;
    assign inc_bubble = ctrl.bubble_id_exe & ctrl.freeze_pc;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_stall),
        .clr (clr_counters),
        .cnt (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_flush),
        .clr (clr_counters),
        .cnt (flush_count)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_bubble),
        .clr (clr_counters),
        .cnt (bubble_count)
    );

    // WDOG_W must be wide enough that 2**WDOG_W > WDOG_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else if (freeze_pc) begin
            if (wdog_cnt != '1) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
                wdog_trip <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with small counters (4 bits)
// and an 8-cycle watchdog; expected values queued by drivers, checked by a monitor.
module tb_pipeline_stall_controller;

    localparam logic [4:0] C_IDLE = 5'b00000;
    localparam logic [4:0] C_MEM  = 5'b11100;
    localparam logic [4:0] C_HAZ  = 5'b11001;
    localparam logic [4:0] C_BR   = 5'b00011;

    logic       clk = 1'b0;
    logic       rst;
    logic       hazard;
    logic       mem_ready;
    logic       branch_taken;
    logic       clr_counters;
    logic       freeze_pc;
    logic       freeze_if_id;
    logic       freeze_back;
    logic       flush_if_id;
    logic       bubble_id_exe;
    logic [3:0] stall_cycles;
    logic [3:0] flush_count;
    logic [3:0] bubble_count;
    logic       wdog_trip;

    logic [4:0]  exp_q[$];
    logic [12:0] cnt_q[$];
    logic [4:0]  mon_ctl;
    logic [12:0] mon_cnt;
    logic [4:0]  ctl_act;
    logic [12:0] cnt_act;
    int          checks = 0;
    int          errors = 0;

    pipeline_stall_controller #(
        .CNT_W       (4),
        .WDOG_CYCLES (8),
        .WDOG_W      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .clr_counters  (clr_counters),
        .freeze_pc     (freeze_pc),
        .freeze_if_id  (freeze_if_id),
        .freeze_back   (freeze_back),
        .flush_if_id   (flush_if_id),
        .bubble_id_exe (bubble_id_exe),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .bubble_count  (bubble_count),
        .wdog_trip     (wdog_trip)
    );

    // Clock and reset
    always #5 clk = ~clk;

    assign ctl_act = {freeze_pc, freeze_if_id, freeze_back, flush_if_id, bubble_id_exe};
    assign cnt_act = {wdog_trip, stall_cycles, flush_count, bubble_count};

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic drive(input logic hz, input logic mr, input logic bt, input logic clr,
                         input logic [4:0] exp_ctl);
        @(posedge clk);
        #1;
        hazard       = hz;
        mem_ready    = mr;
        branch_taken = bt;
        clr_counters = clr;
        exp_q.push_back(exp_ctl);
    endtask

    task automatic expect_cnt(input logic trip, input logic [3:0] st, input logic [3:0] fl,
                              input logic [3:0] bu);
        cnt_q.push_back({trip, st, fl, bu});
    endtask

    task automatic idle_check(input logic trip, input logic [3:0] st, input logic [3:0] fl,
                              input logic [3:0] bu);
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_IDLE);
        expect_cnt(trip, st, fl, bu);
    endtask

    task automatic clear_check(input logic trip);
        drive(1'b0, 1'b1, 1'b0, 1'b1, C_IDLE);
        idle_check(trip, 4'd0, 4'd0, 4'd0);
    endtask

    // Reset is asserted on top of whatever inputs the previous cycle left applied.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(C_IDLE);
        expect_cnt(1'b0, 4'd0, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        hazard       = 1'b0;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        clr_counters = 1'b0;
    endtask

    // Scoreboard monitor: samples on the falling edge, mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_ctl = exp_q.pop_front();
            checks++;
            if (ctl_act !== mon_ctl) begin
                errors++;
                $display("FAIL ctrl {fpc,fifid,fback,flush,bubble} at %0t: got %b expected %b",
                         $time, ctl_act, mon_ctl);
            end
        end
        if (cnt_q.size() > 0) begin
            mon_cnt = cnt_q.pop_front();
            checks++;
            if (cnt_act !== mon_cnt) begin
                errors++;
                $display("FAIL counters {trip,stall,flush,bubble} at %0t: got %b_%0d_%0d_%0d expected %b_%0d_%0d_%0d",
                         $time, cnt_act[12], cnt_act[11:8], cnt_act[7:4], cnt_act[3:0],
                         mon_cnt[12], mon_cnt[11:8], mon_cnt[7:4], mon_cnt[3:0]);
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: bench did not complete within 100000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst          = 1'b1;
        hazard       = 1'b0;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        clr_counters = 1'b0;
        apply_reset();

        // Two hazard cycles
        drive(1'b1, 1'b1, 1'b0, 1'b0, C_HAZ);
        drive(1'b1, 1'b1, 1'b0, 1'b0, C_HAZ);
        idle_check(1'b0, 4'd2, 4'd0, 4'd2);
        clear_check(1'b0);

        // Branch beats hazard
        drive(1'b1, 1'b1, 1'b1, 1'b0, C_BR);
        idle_check(1'b0, 4'd0, 4'd1, 4'd0);
        clear_check(1'b0);

        // Memory stall of 5 cycles, branch pulse in cycle 2, hazard in cycle 1 ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, C_MEM);
        drive(1'b0, 1'b0, 1'b1, 1'b0, C_MEM);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, C_MEM);
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_BR);
        idle_check(1'b0, 4'd5, 4'd1, 4'd0);
        clear_check(1'b0);

        // Branch held through release: one flush only
        drive(1'b0, 1'b0, 1'b0, 1'b0, C_MEM);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, C_MEM);
        drive(1'b0, 1'b1, 1'b1, 1'b0, C_BR);
        idle_check(1'b0, 4'd5, 4'd1, 4'd0);
        clear_check(1'b0);

        // Watchdog: 10 stalled cycles, trip becomes visible after edge 8
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, C_MEM);
            if (k == 8) expect_cnt(1'b0, 4'd7, 4'd0, 4'd0);
            if (k == 9) expect_cnt(1'b1, 4'd8, 4'd0, 4'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_IDLE);
        expect_cnt(1'b1, 4'd10, 4'd0, 4'd0);
        clear_check(1'b1);

        // Reset mid-stall with a pending branch: outputs drop, branch is lost
        drive(1'b1, 1'b0, 1'b1, 1'b0, C_MEM);
        apply_reset();
        idle_check(1'b0, 4'd0, 4'd0, 4'd0);

        // Saturation: 18 hazard cycles hold stall and bubble at 15
        for (int i = 0; i < 18; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, C_HAZ);
        idle_check(1'b1, 4'd15, 4'd0, 4'd15);
        // Clear coincident with a hazard increment
        drive(1'b1, 1'b1, 1'b0, 1'b1, C_HAZ);
        idle_check(1'b1, 4'd0, 4'd0, 4'd0);

        repeat (3) @(posedge clk);
        checks++;
        if ((exp_q.size() != 0) || (cnt_q.size() != 0)) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left expected 0/0", exp_q.size(), cnt_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
